// File: rtl/mem_port_ctrl_pkg.sv
// Shared types for the memory-port controller: FSM states and store widths.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_port_ctrl_pkg;

    // Controller states: waiting for a request, waiting on pmem, one-cycle response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_port_state_t;

    // RV32I store funct3 encodings (same values as rv32i_types).
    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

endpackage

// File: rtl/mem_port_ctrl_byte_lane_align.sv
// Byte-lane aligner: derives byte enables and lane-shifted store data from width and offset.
// Latency: purely combinational.
// Backpressure: none; misaligned also flags unknown store widths so the caller rejects both.
module byte_lane_align
    import mem_port_ctrl_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    logic [1:0] w_off;
    assign w_off = i_addr;

    // Decode store width into lane mask, shifted data and an alignment verdict.
    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = 32'h0;
        o_misaligned = 1'b0;
        case (store_funct3_t'(i_funct3))
            SB: begin
                o_be    = 4'b0001 << w_off;
                o_wdata = i_wdata << {w_off, 3'b000};
            end
            SH: begin
                if (w_off[0]) begin
                    o_misaligned = 1'b1;
                end else begin
                    o_be    = 4'b0011 << w_off;
                    o_wdata = i_wdata << {w_off, 3'b000};
                end
            end
            SW: begin
                if (w_off != 2'b00) begin
                    o_misaligned = 1'b1;
                end else begin
                    o_be    = 4'b1111;
                    o_wdata = i_wdata;
                end
            end
            default: o_misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory-port controller: turns held CPU read/write requests into pmem strobes and a one-cycle response.
// Latency: strobe one cycle after the request, cpu_resp one cycle after pmem_resp (min 2); errors respond in 1.
// Backpressure: waits on pmem_resp up to TIMEOUT_CYCLES, then abandons the access with cpu_err.
module mem_port_ctrl
    import mem_port_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_resp,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_byte_enable,
    input  logic        pmem_resp,
    input  logic [31:0] pmem_rdata
);

    mem_port_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cpu_resp;
    logic             r_cpu_err;
    logic [31:0]      r_cpu_rdata;
    logic             r_pmem_read;
    logic             r_pmem_write;
    logic [31:0]      r_pmem_address;
    logic [31:0]      r_pmem_wdata;
    logic [3:0]       r_pmem_be;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_misaligned;
    logic        w_timeout;

    byte_lane_align u_align (
        .i_funct3     (cpu_funct3),
        .i_addr       (cpu_address[1:0]),
        .i_wdata      (cpu_wdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned)
    );

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Request FSM: accept in IDLE, hold the bus cycle in BUSY, pulse the response in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_cpu_resp     <= 1'b0;
            r_cpu_err      <= 1'b0;
            r_cpu_rdata    <= 32'h0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= 32'h0;
            r_pmem_wdata   <= 32'h0;
            r_pmem_be      <= 4'b0000;
        end else begin
            // Response flags are only ever high for the single RESP cycle.
            r_cpu_resp <= 1'b0;
            r_cpu_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_read && cpu_write) begin
                        r_cpu_resp <= 1'b1;
                        r_cpu_err  <= 1'b1;
                        r_state    <= RESP;
                    end else if (cpu_write) begin
                        if (w_misaligned) begin
                            r_cpu_resp <= 1'b1;
                            r_cpu_err  <= 1'b1;
                            r_state    <= RESP;
                        end else begin
                            r_pmem_address <= cpu_address & ~32'h3;
                            r_pmem_wdata   <= w_wdata;
                            r_pmem_be      <= w_be;
                            r_pmem_write   <= 1'b1;
                            r_cnt          <= '0;
                            r_state        <= BUSY;
                        end
                    end else if (cpu_read) begin
                        // Reads fetch the whole word; the datapath extracts sub-words itself.
                        r_pmem_address <= cpu_address & ~32'h3;
                        r_pmem_be      <= 4'b1111;
                        r_pmem_read    <= 1'b1;
                        r_cnt          <= '0;
                        r_state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        if (r_pmem_read) begin
                            r_cpu_rdata <= pmem_rdata;
                        end
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_cpu_resp   <= 1'b1;
                        r_state      <= RESP;
                    end else if (w_timeout) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_cpu_resp   <= 1'b1;
                        r_cpu_err    <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    // A request still held here belongs to the access just completed.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu_resp         = r_cpu_resp;
    assign cpu_err          = r_cpu_err;
    assign cpu_rdata        = r_cpu_rdata;
    assign pmem_read        = r_pmem_read;
    assign pmem_write       = r_pmem_write;
    assign pmem_address     = r_pmem_address;
    assign pmem_wdata       = r_pmem_wdata;
    assign pmem_byte_enable = r_pmem_be;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Testbench for mem_port_ctrl: directed cases plus randomized traffic against a reference model.
// Latency: checks strobe at cycle 1 and cpu_resp one cycle after pmem_resp or timeout.
// Backpressure: a bench pmem responder inserts random wait states or never responds.
module tb_mem_port_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [2:0]  cpu_funct3 = 3'b0;
    logic [31:0] cpu_address = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_resp;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic        pmem_resp = 1'b0;
    logic [31:0] pmem_rdata = 32'h0;

    mem_port_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_read         (cpu_read),
        .cpu_write        (cpu_write),
        .cpu_funct3       (cpu_funct3),
        .cpu_address      (cpu_address),
        .cpu_wdata        (cpu_wdata),
        .cpu_resp         (cpu_resp),
        .cpu_err          (cpu_err),
        .cpu_rdata        (cpu_rdata),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_resp        (pmem_resp),
        .pmem_rdata       (pmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference store rule: width in bytes, offset must be a multiple of it.
    function automatic void ref_store(input logic [2:0] f3, input logic [1:0] off,
                                      input logic [31:0] d, output logic bad,
                                      output logic [3:0] be, output logic [31:0] wd);
        int size;
        size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        be = 4'b0;
        wd = 32'h0;
        if (size == 0) begin
            bad = 1'b1;
        end else begin
            bad = (int'(off) % size) != 0;
            be  = 4'(((1 << size) - 1) << int'(off));
            wd  = d << (8 * int'(off));
        end
    endfunction

    // One full transaction; entered and left at #1 after a rising edge.
    // lat = wait cycles before pmem_resp, negative = never respond.
    task automatic do_txn(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int lat, input logic [31:0] mem_rd);
        logic        bad;
        logic [3:0]  be;
        logic [31:0] swd;
        logic [31:0] exp_addr;
        bit          err_now;
        bit          tmo;
        exp_t        e;
        ref_store(f3, addr[1:0], wd, bad, be, swd);
        exp_addr = {addr[31:2], 2'b00};
        err_now  = (rd && wr) || (wr && bad);
        if (rd && !wr) be = 4'b1111;

        cpu_read    = rd;
        cpu_write   = wr;
        cpu_funct3  = f3;
        cpu_address = addr;
        cpu_wdata   = wd;

        if (err_now) begin
            e.err = 1'b1;
            e.rdata = model_rdata;
            sb_q.push_back(e);
            @(posedge clk); #1;
            chk("err_resp_cycle1", cpu_resp, 1);
            chk("err_no_strobe", {pmem_read, pmem_write}, 0);
        end else begin
            tmo = (lat < 0);
            e.err = tmo;
            e.rdata = (!tmo && rd) ? mem_rd : model_rdata;
            sb_q.push_back(e);
            if (!tmo && rd) model_rdata = mem_rd;
            @(posedge clk); #1;
            for (int i = 0; i < TO; i++) begin
                chk("strobe_rd", pmem_read, rd);
                chk("strobe_wr", pmem_write, wr);
                chk("pmem_addr", pmem_address, exp_addr);
                chk("pmem_be", pmem_byte_enable, be);
                if (wr) chk("pmem_wdata", pmem_wdata, swd);
                // Inputs sampled only in IDLE: scramble them while busy.
                cpu_wdata  = $urandom;
                cpu_funct3 = 3'($urandom);
                if (i == lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = mem_rd;
                end else begin
                    pmem_rdata = $urandom;
                end
                @(posedge clk); #1;
                pmem_resp = 1'b0;
                if (i == lat) break;
                if (i < TO - 1) chk("no_early_resp", cpu_resp, 0);
            end
            chk("resp_latency", cpu_resp, 1);
            chk("strobe_dropped", {pmem_read, pmem_write}, 0);
        end
        // Request stays high through the RESP cycle; it must not be re-accepted.
        @(posedge clk); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        chk("resp_one_cycle", cpu_resp, 0);
        chk("idle_no_strobe", {pmem_read, pmem_write}, 0);
    endtask

    task automatic idle_gap(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            if (noise) begin
                pmem_resp  = 1'b1;
                pmem_rdata = $urandom;
            end
            @(posedge clk); #1;
            pmem_resp = 1'b0;
        end
    endtask

    // Scoreboard monitor: every cpu_resp must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (cpu_resp === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("mon_err", cpu_err, e.err);
                    chk("mon_rdata", cpu_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_outputs", {cpu_resp, cpu_err, pmem_read, pmem_write, pmem_byte_enable}, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_addr", pmem_address, 0);
        chk("rst_wdata", pmem_wdata, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle_gap(1, 1'b0);

        // Directed cases.
        do_txn(0, 1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 3, 32'h0);
        do_txn(0, 1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 0, 32'h0);
        do_txn(0, 1, 3'b001, 32'h0000_0102, 32'h0000_1234, 1, 32'h0);
        do_txn(0, 1, 3'b001, 32'h0000_0101, 32'h0000_5678, 0, 32'h0);
        do_txn(0, 1, 3'b010, 32'h0000_0102, 32'h1111_2222, 0, 32'h0);
        do_txn(0, 1, 3'b011, 32'h0000_0100, 32'h3333_4444, 0, 32'h0);
        do_txn(1, 1, 3'b010, 32'h0000_0100, 32'h5555_6666, 0, 32'h0);
        do_txn(1, 0, 3'b010, 32'h0000_0205, 32'h0, 0, 32'hCAFEF00D);
        do_txn(0, 1, 3'b000, 32'h0000_0300, 32'h0000_0077, 2, 32'h0);
        do_txn(1, 0, 3'b010, 32'h0000_0400, 32'h0, -1, 32'h0);
        idle_gap(2, 1'b1);

        // Reset while a read is waiting on pmem.
        cpu_read = 1'b1; cpu_address = 32'h0000_0300;
        @(posedge clk); #1;
        chk("pre_rst_strobe", pmem_read, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {cpu_resp, cpu_err, pmem_read, pmem_write, pmem_byte_enable}, 0);
        chk("midrst_rdata", cpu_rdata, 0);
        chk("midrst_addr", pmem_address, 0);
        cpu_read = 1'b0;
        model_rdata = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_gap(2, 1'b1);
        chk("late_resp_ignored", cpu_resp, 0);
        do_txn(1, 0, 3'b010, 32'h0000_0310, 32'h0, 1, 32'h0BAD_F00D);

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            int   kind;
            int   lat;
            logic [2:0] f3;
            kind = $urandom_range(0, 9);
            f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            lat  = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TO - 1);
            do_txn(kind <= 3 || kind == 9, kind >= 4, f3, $urandom, $urandom, lat, $urandom);
            idle_gap($urandom_range(0, 2), $urandom_range(0, 3) == 0);
        end

        idle_gap(3, 1'b0);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
